// File: rtl/sim_run_supervisor.sv
// Run supervisor for the CPU simulation/FPGA harness.
// Sequences the design reset, counts run cycles and commits, and reports the run outcome.
module sim_run_supervisor #(
  parameter int unsigned RST_CYCLES     = 25,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned STALL_CYCLES   = 4096
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             commit_in,
  input  logic             halt_in,
  input  logic             restart_in,
  output logic             dut_rst_out,
  output logic             running_out,
  output logic             done_out,
  output logic             timeout_out,
  output logic             stall_out,
  output logic [CNT_W-1:0] cycle_cnt_out,
  output logic [CNT_W-1:0] commit_cnt_out
);

  localparam int unsigned RW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RLAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ST_V = CNT_W'(STALL_CYCLES);
  localparam bit STALL_EN = (STALL_CYCLES != 0);

  typedef enum logic [1:0] {
    S_RST,
    S_RUN,
    S_DONE,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] com_q, com_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             to_q, to_d;

  logic [CNT_W-1:0] cyc_n, com_n, idle_n;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_RST;
      rcnt_q  <= '0;
      cyc_q   <= '0;
      com_q   <= '0;
      idle_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cyc_q   <= cyc_d;
      com_q   <= com_d;
      idle_q  <= idle_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cyc_d   = cyc_q;
    com_d   = com_q;
    idle_d  = idle_q;
    to_d    = to_q;
    cyc_n   = sat_inc(cyc_q);
    com_n   = commit_in ? sat_inc(com_q) : com_q;
    idle_n  = commit_in ? '0 : sat_inc(idle_q);
    unique case (state_q)
      S_RST: begin
        rcnt_d = rcnt_q + RW'(1);
        if (rcnt_q == RLAST) begin
          state_d = S_RUN;
          rcnt_d  = '0;
        end
      end
      S_RUN: begin
        if (restart_in) begin
          state_d = S_RST;
          rcnt_d  = '0;
          cyc_d   = '0;
          com_d   = '0;
          idle_d  = '0;
          to_d    = 1'b0;
        end else begin
          if (rdy_in) begin
            cyc_d  = cyc_n;
            com_d  = com_n;
            idle_d = idle_n;
          end
          // Paused cycles can still end the run on halt, nothing else.
          if (halt_in) begin
            state_d = S_DONE;
          end else if (rdy_in && cyc_n == TO_V) begin
            state_d = S_FAIL;
            to_d    = 1'b1;
          end else if (rdy_in && STALL_EN && idle_n == ST_V) begin
            state_d = S_FAIL;
            to_d    = 1'b0;
          end
        end
      end
      S_DONE, S_FAIL: begin
        if (restart_in) begin
          state_d = S_RST;
          rcnt_d  = '0;
          cyc_d   = '0;
          com_d   = '0;
          idle_d  = '0;
          to_d    = 1'b0;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  assign dut_rst_out    = (state_q == S_RST);
  assign running_out    = (state_q == S_RUN);
  assign done_out       = (state_q == S_DONE);
  assign timeout_out    = (state_q == S_FAIL) && to_q;
  assign stall_out      = (state_q == S_FAIL) && !to_q;
  assign cycle_cnt_out  = cyc_q;
  assign commit_cnt_out = com_q;

endmodule

// File: tb/tb_sim_run_supervisor.sv
// Directed bench for sim_run_supervisor.
// Small timeout/stall limits keep runs short.
module tb_sim_run_supervisor;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, rdy, commit, halt, restart;
  logic         dut_rst, running, done, tmo, stall;
  logic [W-1:0] cyc, com;

  int tests = 0;
  int fails = 0;

  sim_run_supervisor #(
    .RST_CYCLES    (25),
    .CNT_W         (W),
    .TIMEOUT_CYCLES(100),
    .STALL_CYCLES  (8)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .commit_in     (commit),
    .halt_in       (halt),
    .restart_in    (restart),
    .dut_rst_out   (dut_rst),
    .running_out   (running),
    .done_out      (done),
    .timeout_out   (tmo),
    .stall_out     (stall),
    .cycle_cnt_out (cyc),
    .commit_cnt_out(com)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_run();
    rst = 1'b1; rdy = 1'b1; commit = 1'b0;
    halt = 1'b0; restart = 1'b0;
    step();
    rst = 1'b0;
    repeat (25) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; commit = 1'b1;
    halt = 1'b0; restart = 1'b0;
    repeat (3) step();
    tests++;
    if ({dut_rst, running, done, tmo, stall} !== 5'b10000 ||
        cyc !== 0 || com !== 0) begin
      fails++;
      $display("FAIL reset_state flags=%b cyc=%0d com=%0d exp 10000/0/0",
               {dut_rst, running, done, tmo, stall}, cyc, com);
    end
    rst = 1'b0; rdy = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      tests++;
      if (dut_rst !== (i < 25) || running !== (i == 25) || cyc !== 0) begin
        fails++;
        $display("FAIL reset_len edge=%0d rst=%b run=%b cyc=%0d exp %b %b 0",
                 i, dut_rst, running, cyc, i < 25, i == 25);
      end
    end
  endtask

  task automatic test_halt();
    go_run();
    commit = 1'b1;
    repeat (9) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    tests++;
    if (done !== 1 || running !== 0 || tmo !== 0 || stall !== 0 ||
        cyc !== 10 || com !== 10) begin
      fails++;
      $display("FAIL halt done=%b run=%b cyc=%0d com=%0d exp 1 0 10 10",
               done, running, cyc, com);
    end
    for (int i = 0; i < 50; i++) begin
      commit = i[0];
      halt = (i == 7);
      step();
    end
    halt = 1'b0;
    tests++;
    if (done !== 1 || cyc !== 10 || com !== 10 || dut_rst !== 0) begin
      fails++;
      $display("FAIL halt_hold done=%b cyc=%0d com=%0d exp 1 10 10",
               done, cyc, com);
    end
  endtask

  task automatic test_rdy_gap();
    go_run();
    commit = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      rdy = !(k >= 3 && k <= 7);
      halt = (k == 12);
      step();
      if (k == 7) begin
        tests++;
        if (cyc !== 2 || com !== 2 || running !== 1) begin
          fails++;
          $display("FAIL rdy_freeze cyc=%0d com=%0d run=%b exp 2 2 1",
                   cyc, com, running);
        end
      end
    end
    halt = 1'b0; rdy = 1'b1;
    tests++;
    if (done !== 1 || cyc !== 7 || com !== 7) begin
      fails++;
      $display("FAIL rdy_gap done=%b cyc=%0d com=%0d exp 1 7 7",
               done, cyc, com);
    end
  endtask

  task automatic test_timeout();
    go_run();
    commit = 1'b1;
    repeat (99) step();
    tests++;
    if (running !== 1 || tmo !== 0 || cyc !== 99) begin
      fails++;
      $display("FAIL timeout_pre run=%b tmo=%b cyc=%0d exp 1 0 99",
               running, tmo, cyc);
    end
    step();
    tests++;
    if (tmo !== 1 || done !== 0 || stall !== 0 || running !== 0 ||
        cyc !== 100 || com !== 100) begin
      fails++;
      $display("FAIL timeout tmo=%b done=%b cyc=%0d com=%0d exp 1 0 100 100",
               tmo, done, cyc, com);
    end
    go_run();
    commit = 1'b1;
    repeat (99) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    tests++;
    if (done !== 1 || tmo !== 0 || cyc !== 100) begin
      fails++;
      $display("FAIL halt_vs_timeout done=%b tmo=%b cyc=%0d exp 1 0 100",
               done, tmo, cyc);
    end
  endtask

  task automatic test_stall();
    go_run();
    for (int k = 1; k <= 13; k++) begin
      commit = (k <= 5);
      step();
      if (k == 12) begin
        tests++;
        if (stall !== 0 || running !== 1) begin
          fails++;
          $display("FAIL stall_pre stall=%b run=%b exp 0 1", stall, running);
        end
      end
    end
    tests++;
    if (stall !== 1 || tmo !== 0 || done !== 0 ||
        com !== 5 || cyc !== 13) begin
      fails++;
      $display("FAIL stall stall=%b tmo=%b cyc=%0d com=%0d exp 1 0 13 5",
               stall, tmo, cyc, com);
    end
  endtask

  task automatic test_restart();
    go_run();
    commit = 1'b1;
    repeat (39) step();
    restart = 1'b1;
    step();
    tests++;
    if (dut_rst !== 1 || running !== 0 || cyc !== 0 || com !== 0) begin
      fails++;
      $display("FAIL restart rst=%b run=%b cyc=%0d com=%0d exp 1 0 0 0",
               dut_rst, running, cyc, com);
    end
    for (int i = 1; i <= 25; i++) begin
      restart = (i == 5);
      step();
      tests++;
      if (dut_rst !== (i < 25) || running !== (i == 25)) begin
        fails++;
        $display("FAIL restart_len edge=%0d rst=%b run=%b exp %b %b",
                 i, dut_rst, running, i < 25, i == 25);
      end
    end
    restart = 1'b0;
    repeat (5) step();
    tests++;
    if (cyc !== 5 || com !== 5 || running !== 1) begin
      fails++;
      $display("FAIL rerun cyc=%0d com=%0d run=%b exp 5 5 1",
               cyc, com, running);
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      step();
      tests++;
      if (dut_rst !== (i < 25) || running !== (i == 25)) begin
        fails++;
        $display("FAIL mid_rst edge=%0d rst=%b run=%b exp %b %b",
                 i, dut_rst, running, i < 25, i == 25);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; commit = 1'b0;
    halt = 1'b0; restart = 1'b0;
    test_reset();
    test_halt();
    test_rdy_gap();
    test_timeout();
    test_stall();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
